// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - instruction memory arbiter between fetch and loader/debug requesters
// Fetch has priority; a starvation counter bounds loader wait; LOCKED gives the loader exclusive use.
module imem_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_valid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_err,
  output logic              locked,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-3:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic {RUN, LOCKED} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       l_rd_pend;
  logic       l_aligned;
  logic       l_win;
  logic       unused_ok;

  assign l_aligned = (l_addr[1:0] == 2'b00);
  assign unused_ok = ^f_addr[1:0];

  // Grants and memory drive are combinational from state, counter and requests.
  always_comb begin
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    l_win   = 1'b0;
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (!reset) begin
      if (state == LOCKED) begin
        l_gnt = l_req;
      end else begin
        l_win = l_req && (!f_req || (starve_cnt == LIMIT));
        l_gnt = l_win;
        f_gnt = f_req && !l_win;
      end
      if (f_gnt) begin
        m_en   = 1'b1;
        m_addr = f_addr[ADDR_W-1:2];
      end else if (l_gnt && l_aligned) begin
        m_en   = 1'b1;
        m_we   = l_we;
        m_addr = l_addr[ADDR_W-1:2];
        if (l_we) begin
          m_wdata = l_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      starve_cnt <= '0;
      f_valid    <= 1'b0;
      l_valid    <= 1'b0;
      l_err      <= 1'b0;
      l_rd_pend  <= 1'b0;
    end else begin
      state <= l_lock ? LOCKED : RUN;
      // Counts consecutive lost conflicts; any loader win or idle loader clears it.
      if (state == LOCKED || l_gnt || !l_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      f_valid   <= f_gnt;
      l_valid   <= l_gnt;
      l_err     <= l_gnt && !l_aligned;
      l_rd_pend <= l_gnt && l_aligned && !l_we;
    end
  end

  assign locked  = (state == LOCKED);
  assign f_rdata = f_valid ? m_rdata : '0;
  assign l_rdata = l_rd_pend ? m_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed table-driven bench for imem_arbiter
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req;
  logic [6:0]  f_addr;
  logic        f_gnt, f_valid;
  logic [31:0] f_rdata;
  logic        l_req, l_we, l_lock;
  logic [6:0]  l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt, l_valid, l_err, locked;
  logic [31:0] l_rdata;
  logic        m_en, m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  logic [31:0] mem [0:31];

  int n_tests = 0;
  int n_fail  = 0;

  imem_arbiter #(.ADDR_W(7), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_valid(l_valid), .l_rdata(l_rdata), .l_err(l_err), .locked(locked),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory: preloaded with word i = i * 0x01010101 (word 3 special) while reset is high.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0101_0101 * i;
      mem[3]  <= 32'h2008_0020;
      m_rdata <= '0;
    end else if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  typedef struct {
    logic        f_req;
    logic [6:0]  f_addr;
    logic        l_req;
    logic        l_we;
    logic [6:0]  l_addr;
    logic [31:0] l_wdata;
    logic        l_lock;
    logic        e_f_gnt;
    logic        e_l_gnt;
    logic        e_m_en;
    logic        e_m_we;
    logic [4:0]  e_m_addr;
    logic        e_f_valid;
    logic [31:0] e_f_rdata;
    logic        e_l_valid;
    logic [31:0] e_l_rdata;
    logic        e_l_err;
    logic        e_locked;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fr, input logic [6:0] fa, input logic lr, input logic lw,
                       input logic [6:0] la, input logic [31:0] ld, input logic lk);
    f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; l_lock = lk;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 7'h0C, 1, 0, 7'h10, 0, 0);
    step(); step();
    #1;
    chk("rst.f_gnt", f_gnt, 0);
    chk("rst.l_gnt", l_gnt, 0);
    chk("rst.m_en", m_en, 0);
    chk("rst.m_we", m_we, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step(); #1;
    chk("rst.f_valid", f_valid, 0);
    chk("rst.l_valid", l_valid, 0);
    chk("rst.l_err", l_err, 0);
    chk("rst.locked", locked, 0);

    //             fr fa     lr lw la     wdata          lk  fg lg en we ma  fv fr            lv lr            le lk
    vecs.push_back('{1, 7'h0C, 0, 0, 7'h00, 32'h0,         0,  1, 0, 1, 0, 5'd3, 0, 32'h0,         0, 32'h0,         0, 0});
    vecs.push_back('{0, 7'h00, 1, 1, 7'h10, 32'hDEAD_BEEF, 0,  0, 1, 1, 1, 5'd4, 1, 32'h2008_0020, 0, 32'h0,         0, 0});
    vecs.push_back('{0, 7'h00, 1, 0, 7'h10, 32'h0,         0,  0, 1, 1, 0, 5'd4, 0, 32'h0,         1, 32'h0,         0, 0});
    vecs.push_back('{0, 7'h00, 0, 0, 7'h00, 32'h0,         0,  0, 0, 0, 0, 5'd0, 0, 32'h0,         1, 32'hDEAD_BEEF, 0, 0});
    vecs.push_back('{0, 7'h00, 1, 1, 7'h06, 32'h5555_5555, 0,  0, 1, 0, 0, 5'd0, 0, 32'h0,         0, 32'h0,         0, 0});
    vecs.push_back('{0, 7'h00, 1, 0, 7'h04, 32'h0,         0,  0, 1, 1, 0, 5'd1, 0, 32'h0,         1, 32'h0,         1, 0});
    vecs.push_back('{0, 7'h00, 0, 0, 7'h00, 32'h0,         0,  0, 0, 0, 0, 5'd0, 0, 32'h0,         1, 32'h0101_0101, 0, 0});
    vecs.push_back('{0, 7'h00, 1, 0, 7'h07, 32'h0,         0,  0, 1, 0, 0, 5'd0, 0, 32'h0,         0, 32'h0,         0, 0});
    vecs.push_back('{1, 7'h0D, 0, 0, 7'h00, 32'h0,         0,  1, 0, 1, 0, 5'd3, 0, 32'h0,         1, 32'h0,         1, 0});
    vecs.push_back('{0, 7'h00, 0, 0, 7'h00, 32'h0,         0,  0, 0, 0, 0, 5'd0, 1, 32'h2008_0020, 0, 32'h0,         0, 0});
    vecs.push_back('{1, 7'h08, 1, 0, 7'h10, 32'h0,         0,  1, 0, 1, 0, 5'd2, 0, 32'h0,         0, 32'h0,         0, 0});
    vecs.push_back('{0, 7'h00, 0, 0, 7'h00, 32'h0,         0,  0, 0, 0, 0, 5'd0, 1, 32'h0202_0202, 0, 32'h0,         0, 0});

    foreach (vecs[i]) begin
      step();
      drive(vecs[i].f_req, vecs[i].f_addr, vecs[i].l_req, vecs[i].l_we,
            vecs[i].l_addr, vecs[i].l_wdata, vecs[i].l_lock);
      #1;
      chk($sformatf("v%0d.f_gnt", i),   f_gnt,   vecs[i].e_f_gnt);
      chk($sformatf("v%0d.l_gnt", i),   l_gnt,   vecs[i].e_l_gnt);
      chk($sformatf("v%0d.m_en", i),    m_en,    vecs[i].e_m_en);
      chk($sformatf("v%0d.m_we", i),    m_we,    vecs[i].e_m_we);
      chk($sformatf("v%0d.m_addr", i),  m_addr,  vecs[i].e_m_addr);
      chk($sformatf("v%0d.f_valid", i), f_valid, vecs[i].e_f_valid);
      chk($sformatf("v%0d.f_rdata", i), f_rdata, vecs[i].e_f_rdata);
      chk($sformatf("v%0d.l_valid", i), l_valid, vecs[i].e_l_valid);
      chk($sformatf("v%0d.l_rdata", i), l_rdata, vecs[i].e_l_rdata);
      chk($sformatf("v%0d.l_err", i),   l_err,   vecs[i].e_l_err);
      chk($sformatf("v%0d.locked", i),  locked,  vecs[i].e_locked);
    end
    chk("mis.word1", mem[1], 32'h0101_0101);

    // Starvation: fetch wins cycles 0-3, loader cycle 4, fetch cycle 5.
    for (int c = 0; c < 6; c++) begin
      step();
      drive(1, 7'h0C, 1, 0, 7'h10, 0, 0);
      #1;
      chk($sformatf("starve%0d.f_gnt", c), f_gnt, (c != 4));
      chk($sformatf("starve%0d.l_gnt", c), l_gnt, (c == 4));
      chk($sformatf("starve%0d.m_addr", c), m_addr, (c == 4) ? 5'd4 : 5'd3);
      if (c == 5) chk("starve5.l_rdata", l_rdata, 32'hDEAD_BEEF);
    end

    // Drive counter to the limit, then reset mid-access: counter and pending response dropped.
    for (int c = 0; c < 3; c++) begin
      step();
      drive(1, 7'h0C, 1, 0, 7'h10, 0, 0);
      #1;
      chk($sformatf("pre%0d.f_gnt", c), f_gnt, 1);
    end
    step();
    reset = 1'b1;
    #1;
    chk("midrst.f_gnt", f_gnt, 0);
    chk("midrst.l_gnt", l_gnt, 0);
    chk("midrst.m_en", m_en, 0);
    step();
    reset = 1'b0;
    #1;
    chk("postrst.f_valid", f_valid, 0);
    chk("postrst.l_valid", l_valid, 0);
    chk("postrst.locked", locked, 0);
    chk("postrst.f_gnt", f_gnt, 1);
    chk("postrst.l_gnt", l_gnt, 0);

    // Lock rise with conflict: RUN rules this cycle, fetch response still delivered.
    step();
    drive(1, 7'h0C, 1, 0, 7'h10, 0, 1);
    #1;
    chk("lockrise.f_gnt", f_gnt, 1);
    chk("lockrise.l_gnt", l_gnt, 0);
    chk("lockrise.locked", locked, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      drive(1, 7'h0C, 1, 1, 7'h20 + 7'(4 * k), 32'hA5A5_0000 + k, 1);
      #1;
      chk($sformatf("lock%0d.f_gnt", k), f_gnt, 0);
      chk($sformatf("lock%0d.l_gnt", k), l_gnt, 1);
      chk($sformatf("lock%0d.m_we", k), m_we, 1);
      chk($sformatf("lock%0d.m_addr", k), m_addr, 5'(8 + k));
      chk($sformatf("lock%0d.locked", k), locked, 1);
      chk($sformatf("lock%0d.l_valid", k), l_valid, (k > 0));
      if (k == 0) chk("lock0.f_rdata", f_rdata, 32'h2008_0020);
      else        chk($sformatf("lock%0d.l_rdata", k), l_rdata, 0);
    end
    step();
    drive(1, 7'h0C, 0, 0, 0, 0, 0);
    #1;
    chk("unlock.f_gnt", f_gnt, 0);
    chk("unlock.locked", locked, 1);
    chk("unlock.l_valid", l_valid, 1);
    step();
    #1;
    chk("run.f_gnt", f_gnt, 1);
    chk("run.locked", locked, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    for (int k = 0; k < 8; k++) chk($sformatf("lockmem%0d", k), mem[8 + k], 32'hA5A5_0000 + k);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
